// File: rtl/mux_1_pkg.sv
// mux_1_pkg: shared constants and types for the mux_1 data selector.
// Holds default widths, the select-transition counter ceiling and the
// select encoding used by mux_1 and mux_1_sat_cnt.
package mux_1_pkg;

   // Default data width of a, b, y and y_q
   localparam int unsigned WIDTH_DEF = 1;

   // Default width of the select-transition counter
   localparam int unsigned CNT_W_DEF = 8;

   // Ceiling of a default-width transition counter; it holds here rather than wrapping
   localparam logic [CNT_W_DEF-1:0] CNT_SAT = '1;

   // Select encoding: which source is forwarded
   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_e;

endpackage

// File: rtl/mux_1_sat_cnt.sv
// mux_1_sat_cnt: generic saturating up-counter.
// Counts one per enabled clock edge, sticks at all-ones, and clears
// asynchronously on rst_n low.
module mux_1_sat_cnt
   import mux_1_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] CntMax = '1;

   logic [WIDTH-1:0] cnt_d;

   // Next count: advance when enabled unless already at the ceiling
   always_comb begin
      cnt_d = cnt;
      if (en && (cnt != CntMax)) begin
         cnt_d = cnt + WIDTH'(1);
      end
   end

   // Counter register with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_1.sv
// mux_1: 2:1 data selector with combinational and registered outputs plus
// select-transition tracking (sel_q, sw_pulse).
// Optional feature macro MUX_1_SWCNT_EN adds the saturating sw_cnt port and
// its counter; without it the port and counter are absent.
module mux_1
   import mux_1_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s0,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             sel_q,
   output logic             sw_pulse
`ifdef MUX_1_SWCNT_EN
   ,
   output logic [CNT_W-1:0] sw_cnt
`endif
);

   // Elaboration-time range guards
   if ((WIDTH < 1) || (WIDTH > 64)) begin : g_width_chk
      $error("mux_1: WIDTH must be within 1..64");
   end
   if (CNT_W < 1) begin : g_cnt_w_chk
      $error("mux_1: CNT_W must be at least 1");
   end

   logic sw_det;

   // Select data; any select value other than a clean 1 (X/Z in sim) falls back to a
   always_comb begin
      y = a;
      if (s0 == SEL_B) begin
         y = b;
      end
   end

   // Flag a select change relative to the last captured select
   always_comb begin
      sw_det = 1'b0;
      if (s0 != sel_q) begin
         sw_det = 1'b1;
      end
   end

   // Registered copies of the selected data, the select and the change flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q      <= '0;
         sel_q    <= SEL_A;
         sw_pulse <= 1'b0;
      end else begin
         y_q      <= y;
         sel_q    <= s0;
         sw_pulse <= sw_det;
      end
   end

`ifdef MUX_1_SWCNT_EN
   mux_1_sat_cnt #(
      .WIDTH (CNT_W)
   ) u_sw_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (sw_det),
      .cnt   (sw_cnt)
   );
`endif

endmodule

// File: tb/tb_mux_1.sv
// tb_mux_1: directed-vector bench for mux_1.
// Instance u_dut_n: WIDTH=1, CNT_W=8 (bit sweep, reset, transition counting).
// Instance u_dut_w: WIDTH=16, CNT_W=2 (wide data, saturation).
// sw_cnt is connected and checked only when MUX_1_SWCNT_EN is defined.
module tb_mux_1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       a_n = 1'b0, b_n = 1'b0, s_n = 1'b0;
   logic       y_n, yq_n, selq_n, swp_n;
   logic [7:0] cnt_n;

   logic [15:0] a_w = 16'hA5A5, b_w = 16'h5A5A;
   logic        s_w = 1'b0;
   logic [15:0] y_w, yq_w;
   logic        selq_w, swp_w;
   logic [1:0]  cnt_w;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   mux_1 #(
      .WIDTH (1),
      .CNT_W (8)
   ) u_dut_n (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a_n),
      .b        (b_n),
      .s0       (s_n),
      .y        (y_n),
      .y_q      (yq_n),
      .sel_q    (selq_n),
      .sw_pulse (swp_n)
`ifdef MUX_1_SWCNT_EN
      ,
      .sw_cnt   (cnt_n)
`endif
   );

   mux_1 #(
      .WIDTH (16),
      .CNT_W (2)
   ) u_dut_w (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a_w),
      .b        (b_w),
      .s0       (s_w),
      .y        (y_w),
      .y_q      (yq_w),
      .sel_q    (selq_w),
      .sw_pulse (swp_w)
`ifdef MUX_1_SWCNT_EN
      ,
      .sw_cnt   (cnt_w)
`endif
   );

`ifndef MUX_1_SWCNT_EN
   assign cnt_n = '0;
   assign cnt_w = '0;
`endif

   // Sweep of {a,b,s0} = 0..7 and the hand-computed y for each
   localparam logic SWEEP_Y [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   // Wide-data steps: a, b, s0, expected y, expected sw_cnt (CNT_W=2) after the edge
   localparam logic [15:0] W_A [6] = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 16'h0F0F, 16'h0F0F, 16'h0000};
   localparam logic [15:0] W_B [6] = '{16'h5A5A, 16'h5A5A, 16'hBEEF, 16'hBEEF, 16'hFFFF, 16'hFFFF};
   localparam logic        W_S [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam logic [15:0] W_Y [6] = '{16'h5A5A, 16'hA5A5, 16'hBEEF, 16'h0F0F, 16'hFFFF, 16'h0000};
   localparam logic [1:0]  W_C [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check_vec("rst_yq_n", 64'(yq_n), 64'h0);
      check_vec("rst_selq_n", 64'(selq_n), 64'h0);
      check_vec("rst_swp_n", 64'(swp_n), 64'h0);
      check_vec("rst_yq_w", 64'(yq_w), 64'h0);
      check_vec("rst_y_w_live", 64'(y_w), 64'hA5A5);
`ifdef MUX_1_SWCNT_EN
      check_vec("rst_cnt_n", 64'(cnt_n), 64'h0);
`endif
      rst_n = 1'b1;

      // Exhaustive 1-bit sweep
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         {a_n, b_n, s_n} = 3'(i);
         #1;
         check_vec($sformatf("sweep_y[%0d]", i), 64'(y_n), 64'(SWEEP_Y[i]));
         @(posedge clk);
         #1;
         check_vec($sformatf("sweep_yq[%0d]", i), 64'(yq_n), 64'(SWEEP_Y[i]));
         check_vec($sformatf("sweep_selq[%0d]", i), 64'(selq_n), 64'(i % 2));
         check_vec($sformatf("sweep_swp[%0d]", i), 64'(swp_n), 64'(i != 0));
      end
`ifdef MUX_1_SWCNT_EN
      check_vec("sweep_cnt", 64'(cnt_n), 64'd7);
`endif

      // Asynchronous reset between edges
      @(negedge clk);
      a_n = 1'b1; b_n = 1'b0; s_n = 1'b1;
      @(posedge clk);
      #1;
      check_vec("prerst_selq", 64'(selq_n), 64'h1);
      check_vec("prerst_y", 64'(y_n), 64'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check_vec("arst_yq", 64'(yq_n), 64'h0);
      check_vec("arst_selq", 64'(selq_n), 64'h0);
      check_vec("arst_swp", 64'(swp_n), 64'h0);
      check_vec("arst_y", 64'(y_n), 64'h0);
`ifdef MUX_1_SWCNT_EN
      check_vec("arst_cnt", 64'(cnt_n), 64'h0);
`endif
      @(posedge clk);
      #1;
      check_vec("hold_selq", 64'(selq_n), 64'h0);
      check_vec("hold_swp", 64'(swp_n), 64'h0);
      check_vec("hold_y", 64'(y_n), 64'h0);

      // Transition counting: first edge with s0=1 counts against sel_q=0
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) rst_n = 1'b1;
         s_n = (k % 2 == 0) ? 1'b1 : 1'b0;
         @(posedge clk);
         #1;
         check_vec($sformatf("tog_swp[%0d]", k), 64'(swp_n), 64'h1);
`ifdef MUX_1_SWCNT_EN
         check_vec($sformatf("tog_cnt[%0d]", k), 64'(cnt_n), 64'(k + 1));
`endif
      end
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check_vec($sformatf("steady_swp[%0d]", k), 64'(swp_n), 64'h0);
`ifdef MUX_1_SWCNT_EN
         check_vec($sformatf("steady_cnt[%0d]", k), 64'(cnt_n), 64'd5);
`endif
      end

      // Wide data baseline with s0=0
      @(negedge clk);
      s_w = 1'b0;
      #1;
      check_vec("wide_y0", 64'(y_w), 64'hA5A5);
      @(posedge clk);
      #1;
      check_vec("wide_yq0", 64'(yq_w), 64'hA5A5);
      check_vec("wide_swp0", 64'(swp_w), 64'h0);

      // Wide data toggles with simultaneous data changes; counter saturates at 3
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         a_w = W_A[k]; b_w = W_B[k]; s_w = W_S[k];
         #1;
         check_vec($sformatf("wide_y[%0d]", k), 64'(y_w), 64'(W_Y[k]));
         if (k > 0) begin
            check_vec($sformatf("wide_lag[%0d]", k), 64'(yq_w), 64'(W_Y[k-1]));
         end
         @(posedge clk);
         #1;
         check_vec($sformatf("wide_yq[%0d]", k), 64'(yq_w), 64'(W_Y[k]));
         check_vec($sformatf("wide_swp[%0d]", k), 64'(swp_w), 64'h1);
`ifdef MUX_1_SWCNT_EN
         check_vec($sformatf("sat_cnt[%0d]", k), 64'(cnt_w), 64'(W_C[k]));
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
